// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built on a single full-adder cell
//
// Modules:
//   add_1bit     : combinational full adder (a + b + cin -> s, cout).
//   serial_adder : loads two WIDTH-bit operands on start, adds them one bit
//                  per clock LSB first through one add_1bit, then registers
//                  the result and pulses done for one cycle.
//
// serial_adder ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   start  in   request; accepted in IDLE or DONE, ignored while busy
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   cin    in   carry-in, sampled on the accepting edge
//   busy   out  high while bits are being added
//   done   out  one-cycle completion pulse
//   sum    out  registered result, changes only on completion or reset
//   cout   out  registered carry-out of the MSB
//   ovf    out  (only with SERIAL_ADD_OVF_EN) two's-complement overflow
//
// Optional feature macro: SERIAL_ADD_OVF_EN

module add_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               fa_s;
  logic               fa_cout;
  logic               accept;
  logic               last_bit;
  logic [WIDTH:0]     part_ext;
  logic               unused_part_lsb;

  add_1bit u_add_1bit (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // start is honoured only when no addition is in flight; DONE is included
  // so that results can be produced back-to-back every WIDTH+1 cycles.
  assign accept   = start && (state_q != S_RUN);
  assign last_bit = (cnt_q == LAST_BIT);

  // New sum bit enters at the MSB; after WIDTH shifts the LSB of the result
  // has travelled down to bit 0. The old bit 0 falls off the end each cycle.
  assign part_ext        = {fa_s, part_q};
  assign unused_part_lsb = part_ext[0];

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    part_d  = part_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          part_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        part_d  = part_ext[WIDTH:1];
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = part_ext[WIDTH:1];
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this final bit.
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Status is decoded straight from the state register so reset clears it
  // in the same instant as the flops.
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int checks   = 0;
  int failures = 0;

  // Scoreboard entry: {ovf, cout, sum}
  logic [9:0] exp_q[$];
  logic [9:0] last_res;

  always #5 clock = ~clock;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] r;
    logic       v;
    r = {1'b0, x} + {1'b0, y} + {8'b0, c};
    v = (x[7] == y[7]) && (r[7] != x[7]);
    return {v, r};
  endfunction

  // Drive a start pulse for one cycle; returns at the negedge after the
  // accepting edge. Expected result is pushed to the scoreboard.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    exp_q.push_back(model(ta, tb_v, tc));
    @(negedge clock);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, checking that sum/cout hold the previous result
  // while running, then pop the scoreboard and compare.
  task automatic wait_done(input string tag, input int exp_lat);
    int         lat;
    logic [9:0] e;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      check({tag, "_busy"}, busy, 1);
      check({tag, "_hold_sum"}, sum, last_res[7:0]);
      check({tag, "_hold_cout"}, cout, last_res[8]);
      @(negedge clock);
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
    if (lat >= 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, sum, e[7:0]);
      check({tag, "_cout"}, cout, e[8]);
      check({tag, "_busy_in_done"}, busy, 0);
`ifdef SERIAL_ADD_OVF_EN
      check({tag, "_ovf"}, ovf, e[9]);
`endif
      last_res = e;
    end
  endtask

  initial begin
    int n_done;
    reset    = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    last_res = '0;

    // Reset state
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // 0x0F + 0x01
    issue(8'h0F, 8'h01, 1'b0);
    wait_done("t1", WIDTH);
    @(negedge clock);
    check("t1_done_one_cycle", done, 0);
    check("t1_idle_busy", busy, 0);

    // 0xFF + 0x01, then back-to-back 0xFF + 0x00 + 1 issued in the done cycle
    issue(8'hFF, 8'h01, 1'b0);
    wait_done("t2a", WIDTH);
    issue(8'hFF, 8'h00, 1'b1);
    check("t2_b2b_busy", busy, 1);
    wait_done("t2b", WIDTH);
    @(negedge clock);
    check("t2_done_one_cycle", done, 0);

    // Second start during RUN must be ignored
    issue(8'h12, 8'h34, 1'b0);
    @(negedge clock);
    @(negedge clock);
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("t3", WIDTH - 3);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done === 1'b1) n_done++;
    end
    check("t3_single_done", n_done, 0);
    check("t3_sum_held", sum, 8'h46);

    // Sum stays 0x46 throughout RUN, becomes 0x02 only at completion
    issue(8'h01, 8'h01, 1'b0);
    wait_done("t4", WIDTH);
    @(negedge clock);

    // Asynchronous reset mid-RUN
    issue(8'h55, 8'hAA, 1'b1);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_sum", sum, 0);
    check("t5_rst_cout", cout, 0);
    exp_q.delete();
    last_res = '0;
    @(negedge clock);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done === 1'b1) n_done++;
    end
    check("t5_no_done_after_rst", n_done, 0);
    issue(8'h80, 8'h7F, 1'b1);
    wait_done("t5_after", WIDTH);
    @(negedge clock);

    // Additional pattern with carry-in only
    issue(8'h00, 8'h00, 1'b1);
    wait_done("t6", WIDTH);
    @(negedge clock);

`ifdef SERIAL_ADD_OVF_EN
    issue(8'h7F, 8'h01, 1'b0);
    wait_done("ovf_a", WIDTH);
    @(negedge clock);
    issue(8'h80, 8'h80, 1'b0);
    wait_done("ovf_b", WIDTH);
    @(negedge clock);
    issue(8'h10, 8'h20, 1'b0);
    wait_done("ovf_c", WIDTH);
    @(negedge clock);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one add_1bit full-adder instance and a carry flip-flop.
- Operands are loaded on a start pulse and added one bit per clock, LSB first.
- The result word and carry-out are registered, then a one-cycle done pulse is issued.
- Sits directly downstream of add_1bit: it is the first block to consume the full-adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge of clock.
- a  input  WIDTH  operand A; sampled only on the edge that accepts start.
- b  input  WIDTH  operand B; sampled only on the edge that accepts start.
- cin  input  1  carry-in; sampled only on the edge that accepts start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum and cout are valid from that cycle.
- sum  output  WIDTH  registered result; holds its value until the next completion.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - Internal shift registers, carry FF and bit counter = 0.
  - Any in-flight addition is discarded; the sum register is also cleared.
- State IDLE, and DONE with start = 1 on an edge:
  - Load sa <= a, sb <= b, carry <= cin, cnt <= 0, state <= RUN.
  - busy = 1 from the next cycle.
- State RUN, each edge:
  - add_1bit inputs are sa[0], sb[0], carry.
  - Shift the adder sum bit into the partial-result register at the MSB, shifting the rest right.
  - sa and sb shift right by one; carry <= adder cout; cnt <= cnt+1.
- RUN, final bit (edge where cnt == WIDTH-1):
  - sum <= completed partial result including this bit.
  - cout <= adder cout.
  - state <= DONE.
- State DONE:
  - Lasts exactly one cycle; done = 1, busy = 0.
  - Next edge goes to IDLE, or to RUN if start = 1 (back-to-back operation allowed).
- Latency:
  - start accepted on edge E0; done high in the cycle following edge E_WIDTH.
  - For WIDTH=8, done is high between E8 and E9.
  - Throughput: one result per WIDTH+1 cycles.
- start while busy = 1 is ignored; the operands and state of the addition in progress are unaffected.
- Outputs sum and cout change only on the completion edge (or reset); they do not show partial results.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- Counter width is clog2(WIDTH+1); WIDTH = 1 gives a single RUN cycle.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, registered, reset 0).
  - On the completion edge: ovf <= carry into MSB XOR carry out of MSB (two's-complement signed overflow).
  - Updated together with sum.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=8; a=0x0F, b=0x01, cin=0, start for 1 cycle -> busy high 8 cycles; done in the cycle after the 8th edge following the start edge; sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 issued with start in the done cycle -> accepted back-to-back; sum=0x00, cout=1 9 cycles later.
- Start accepted with a=0x12, b=0x34; start pulsed again 3 cycles later with a=0xFF, b=0xFF -> second start ignored; sum=0x46, cout=0; only one done pulse.
- Reset asserted asynchronously mid-RUN (cycle 4) -> busy, done, sum, cout all 0 immediately; no done pulse afterwards; a new start then yields the correct result.
- sum stability: after result 0x46, start a=0x01, b=0x01 -> sum remains 0x46 throughout RUN, changes to 0x02 only at completion.
- With SERIAL_ADD_OVF_EN: 0x7F+0x01 -> ovf=1, cout=0; 0x80+0x80 -> sum=0x00, ovf=1, cout=1; 0x10+0x20 -> ovf=0.
